av_note_scheduler: RTL
======================

AV_NOTE_SCHEDULER -- requirements
Module: av_note_scheduler

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning width of the song ROM address.
REQ-002 SHALL have parameter LOOKAHEAD, default 16'd2000, meaning the ms window ahead of song_time in which notes are issued.
REQ-003 SHALL have port clk65  input  1  meaning 65 MHz pixel-domain clock; the only clock.
REQ-004 SHALL have port reset  input  1  meaning asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  meaning single-cycle pulse that begins or restarts the song from ROM address 0.
REQ-006 SHALL have port pause  input  1  meaning high blocks all note issue.
REQ-007 SHALL have port song_time  input  16  meaning current song time in ms.
REQ-008 SHALL have port rom_addr  output  ADDR_W  meaning note-ROM read address.
REQ-009 SHALL have port rom_data  input  32  meaning note record, valid one cycle after rom_addr: [31:16] note time, [15:13] string 0-5, [12:8] fret, [7] end flag, [6:0] ignored.
REQ-010 SHALL have port fret  output  30  meaning per-string fret fields; string s occupies [5s+4:5s].
REQ-011 SHALL have port fret_time  output  16  meaning note time of the most recently issued note.
REQ-012 SHALL have port fret_en  output  6  meaning one-hot, one-cycle issue strobe; bit s = string s.
REQ-013 SHALL have port busy  output  1  meaning scheduler is between start and done.
REQ-014 SHALL have port done  output  1  meaning end of song reached; held until start or reset.
REQ-015 SHALL have port dropped_count  output  8  meaning count of late notes discarded.

Function
REQ-016 SHALL implement states IDLE, FETCH, CHECK, WAIT, ISSUE, DONE.
REQ-017 SHALL go IDLE->FETCH on start, with rom_addr=0, busy=1, done=0.
REQ-018 SHALL, in FETCH, hold rom_addr for one cycle and then go to CHECK, registering rom_data into a note register on that transition.
REQ-019 SHALL, in CHECK, go to DONE when the end flag is set, ignoring all other fields.
REQ-020 SHALL, in CHECK, treat a string field >5 as invalid: no strobe, advance the address, return to FETCH.
REQ-021 SHALL compute the due condition as note_time <= min(song_time+LOOKAHEAD, 16'hFFFF), using a 17-bit sum that saturates and never wraps.
REQ-022 SHALL, in CHECK or WAIT with due=1 and pause=0, go to ISSUE; otherwise go to or stay in WAIT, re-evaluating every cycle.
REQ-023 SHALL, in ISSUE: pulse fret_en[s] for exactly one cycle; load fret[5s+4:5s] and fret_time in the same cycle; leave the other strings' fret fields unchanged; advance rom_addr.
REQ-024 SHALL leave ISSUE for FETCH, or for DONE when rom_addr was 2^ADDR_W-1, with no address wrap.
REQ-025 SHALL make fret_en all-zero in every state except ISSUE, and never assert more than one bit.
REQ-026 SHALL, in DONE, hold busy=0 and done=1 and stay there until start.
REQ-027 SHALL let a start in any state, including mid-fetch or issue, win over all else: go to FETCH with rom_addr=0, clear done, suppress fret_en that cycle, and leave fret and fret_time unchanged.
REQ-028 SHALL, while pause=1, freeze the FSM in WAIT/CHECK; a FETCH already begun completes into CHECK.
REQ-029 SHALL issue notes strictly in ROM order, at most one note per 3 cycles.

Reset
REQ-030 SHALL, while reset is high, asynchronously force state=IDLE, rom_addr=0, fret=0, fret_time=0, fret_en=0, busy=0, done=0, dropped_count=0.
REQ-031 SHALL ignore start while reset is high, and resume operation on the first clk65 edge after reset is released.

Configuration
REQ-032 SHALL, with AV_SCHED_LATE_DROP_EN defined, treat a note with note_time+LOOKAHEAD < song_time in CHECK as late: drop it without a strobe, saturating-increment dropped_count (stops at 255), advance the address and go to FETCH.
REQ-033 SHALL, with AV_SCHED_LATE_DROP_EN undefined, issue late notes normally and tie dropped_count to 0.

Verification
REQ-034 SHALL verify: start, song_time=0, ROM[0]={1500,s2,f7}, ROM[1]=end -> fret_en=6'b000100 for one cycle, fret[14:10]=7, fret_time=1500, then done=1.
REQ-035 SHALL verify: ROM[0] time 5000, song_time ramps from 0 -> no strobe until song_time=3000, then a strobe exactly 1 cycle after the CHECK/WAIT evaluation.
REQ-036 SHALL verify: a due note with pause=1 for 100 cycles -> fret_en stays 0; pause dropped -> strobe within 1 cycle.
REQ-037 SHALL verify: song_time=16'hFF00 and note time 16'hFFFF -> issued (saturated compare); string field 7 -> skipped, no strobe.
REQ-038 SHALL verify: reset asserted in ISSUE -> fret_en=0 immediately, all outputs at reset values; start mid-WAIT -> rom_addr=0 on the next cycle.
REQ-039 SHALL verify: with AV_SCHED_LATE_DROP_EN, song_time=9000 and notes at 1000 and 9500 -> first dropped, dropped_count=1, second issued; without the macro both are issued.

Source files
------------

// File: rtl/av_note_scheduler.sv
// Note scheduler: walks a song ROM in order and issues one-cycle per-string fret strobes.
// Optional feature macro: AV_SCHED_LATE_DROP_EN (drops notes that are already late).
module av_note_scheduler #(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [15:0] LOOKAHEAD = 16'd2000
) (
  input  logic              clk65,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  input  logic [15:0]       song_time,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic [29:0]       fret,
  output logic [15:0]       fret_time,
  output logic [5:0]        fret_en,
  output logic              busy,
  output logic              done,
  output logic [7:0]        dropped_count
);

  localparam int unsigned NUM_STRINGS = 6;
  localparam int unsigned FRET_W      = 5;

  typedef enum logic [2:0] {IDLE, FETCH, CHECK, WAIT, ISSUE, DONE} state_t;

  state_t      state;
  logic        fetch_wait;
  logic [15:0] note_time;
  logic [2:0]  note_string;
  logic [4:0]  note_fret;
  logic        note_end;

  logic [16:0] horizon_sum;
  logic [15:0] horizon;
  logic        due;
  logic        invalid;
  logic        late;
  logic        addr_last;
  logic        advance;
  logic        issue_go;
  logic [6:0]  unused_bits;

  assign unused_bits = rom_data[6:0];

  // Issue window: saturating 17-bit horizon so a late song never wraps to a small limit.
  always_comb begin
    horizon_sum = {1'b0, song_time} + {1'b0, LOOKAHEAD};
    horizon     = horizon_sum[16] ? 16'hFFFF : horizon_sum[15:0];
    due         = note_time <= horizon;
    invalid     = note_string > 3'd5;
    addr_last   = rom_addr == {ADDR_W{1'b1}};
`ifdef AV_SCHED_LATE_DROP_EN
    late        = ({1'b0, note_time} + {1'b0, LOOKAHEAD}) < {1'b0, song_time};
`else
    late        = 1'b0;
`endif
    advance     = (state == ISSUE) ||
                  (state == CHECK && !pause && !note_end && (invalid || late));
    issue_go    = !pause && due &&
                  ((state == CHECK && !note_end && !invalid && !late) || state == WAIT);
  end

  always_ff @(posedge clk65 or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      fetch_wait  <= 1'b0;
      rom_addr    <= '0;
      note_time   <= '0;
      note_string <= '0;
      note_fret   <= '0;
      note_end    <= 1'b0;
      fret        <= '0;
      fret_time   <= '0;
      fret_en     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      fret_en <= '0;
      if (start) begin
        state      <= FETCH;
        fetch_wait <= 1'b1;
        rom_addr   <= '0;
        busy       <= 1'b1;
        done       <= 1'b0;
      end else if (advance) begin
        // Last ROM word consumed: finish rather than wrap the address.
        if (addr_last) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          rom_addr   <= rom_addr + 1'b1;
          state      <= FETCH;
          fetch_wait <= 1'b1;
        end
      end else if (issue_go) begin
        state     <= ISSUE;
        fret_en   <= 6'b1 << note_string;
        fret_time <= note_time;
        for (int s = 0; s < NUM_STRINGS; s++) begin
          if (note_string == 3'(s)) fret[s*FRET_W +: FRET_W] <= note_fret;
        end
      end else begin
        case (state)
          FETCH: begin
            // First FETCH cycle lets the synchronous ROM catch up with rom_addr.
            if (fetch_wait) begin
              fetch_wait <= 1'b0;
            end else begin
              note_time   <= rom_data[31:16];
              note_string <= rom_data[15:13];
              note_fret   <= rom_data[12:8];
              note_end    <= rom_data[7];
              state       <= CHECK;
            end
          end
          CHECK: begin
            if (!pause) begin
              if (note_end) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= WAIT;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef AV_SCHED_LATE_DROP_EN
  logic [7:0] drop_count;

  always_ff @(posedge clk65 or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (!start && state == CHECK && !pause && !note_end && !invalid && late &&
                 drop_count != 8'hFF) begin
      drop_count <= drop_count + 8'd1;
    end
  end

  assign dropped_count = drop_count;
`else
  assign dropped_count = '0;
`endif

endmodule
